// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: two valid/ready requesters share one write port,
// plus a pending-write scoreboard for decode. Define REGFILE_WB_RR_EN for round-robin tie-breaking.
module regfile_wb_arbiter #(
    parameter  int NUM_REGS = 32,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_data,

    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,

    input  logic [ADDR_W-1:0] chk_addr0,
    input  logic [ADDR_W-1:0] chk_addr1,
    output logic              chk_busy0,
    output logic              chk_busy1,

    output logic [ADDR_W-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              rf_wren,
    output logic              grant_last
);

    logic                grant0;
    logic                grant1;
    logic                tie_pick1;

    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wren_q,  wren_d;
    logic                grant_last_q, grant_last_d;

    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [NUM_REGS-1:0] sb_set;
    logic [NUM_REGS-1:0] sb_clr;

    // Tie-break: grant_last_q resets to 1, so port 0 takes the first tie in round-robin mode.
`ifdef REGFILE_WB_RR_EN
    assign tie_pick1 = ~grant_last_q;
`else
    assign tie_pick1 = 1'b1;
`endif

    assign grant1 = req1_valid && (!req0_valid || tie_pick1);
    assign grant0 = req0_valid && !grant1;

    // A requester held in reset must not see a handshake the flops will never capture.
    assign req0_ready = grant0 && rst_n;
    assign req1_ready = grant1 && rst_n;

    always_comb begin
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wren_d       = 1'b0;
        grant_last_d = grant_last_q;
        if (grant1) begin
            waddr_d      = req1_addr;
            wdata_d      = req1_data;
            wren_d       = (req1_addr != '0);
            grant_last_d = 1'b1;
        end else if (grant0) begin
            waddr_d      = req0_addr;
            wdata_d      = req0_data;
            wren_d       = (req0_addr != '0);
            grant_last_d = 1'b0;
        end
    end

    // Register 0 is hard-wired zero, so it can never be marked pending.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            assign sb_clr[gi] = wren_q && (waddr_q == ADDR_W'(gi));
            if (gi == 0) begin : g_r0
                assign sb_set[gi] = 1'b0;
            end else begin : g_rn
                assign sb_set[gi] = alloc_valid && (alloc_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    // Set beats clear: an alloc on the write-back edge belongs to a newer writer.
    always_comb begin
        sb_d = (sb_q & ~sb_clr) | sb_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q      <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            grant_last_q <= 1'b1;
            sb_q         <= '0;
        end else begin
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wren_q       <= wren_d;
            grant_last_q <= grant_last_d;
            sb_q         <= sb_d;
        end
    end

    assign chk_busy0  = sb_q[chk_addr0];
    assign chk_busy1  = sb_q[chk_addr1];
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = wdata_q;
    assign rf_wren    = wren_q;
    assign grant_last = grant_last_q;

endmodule
